multiplier_param_v7: RTL and testbench
======================================

Name: multiplier_param_v7

Overview:
Parametrised iterative integer multiplier for the RV32M accelerator. It is the successor of the fixed 32-bit multiplier and is generalised in operand width and bits retired per cycle. It adds a valid/ready request/response handshake and a synchronous flush. It covers MUL/MULH/MULHSU/MULHU through the signed_A_i, signed_B_i and upper_i controls, and sits between the decode/issue stage and the writeback mux.

Parameters:
WIDTH, 32, operand and result width in bits.
RADIX_BITS, 2, multiplier (B) bits consumed per iteration. WIDTH % RADIX_BITS must be 0, otherwise elaboration fails.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  block can accept a request.
op_A_i  in  WIDTH  multiplicand.
op_B_i  in  WIDTH  multiplier.
signed_A_i  in  1  treat op_A_i as two's complement.
signed_B_i  in  1  treat op_B_i as two's complement.
upper_i  in  1  1 returns product[2W-1:W]; 0 returns product[W-1:0].
flush_i  in  1  synchronous abort.
resp_valid_o  out  1  result valid.
resp_ready_i  in  1  consumer accepts result.
result_o  out  WIDTH  selected product half.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, result_o=0, all internal registers 0.
- Accept: a request is taken when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. Operands and controls are latched at accept and are ignored afterwards.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE (on accept):
  - A_mag = |op_A_i| if signed_A_i and the MSB is set, else op_A_i. B_mag is formed the same way.
  - neg = (signed_A_i & A_msb) ^ (signed_B_i & B_msb).
  - Accumulator of 2*WIDTH bits is cleared. Iteration counter = N-1, where N = WIDTH/RADIX_BITS.
  - Magnitudes are WIDTH-bit unsigned, so the most-negative operand (2^(W-1)) is representable.
- CALC (N cycles): each cycle, acc = (acc + ((A_mag * B_mag[RADIX_BITS-1:0]) << WIDTH)) >> RADIX_BITS, and B_mag >>= RADIX_BITS. The add is WIDTH+RADIX_BITS bits wide with carry kept. Leave to FIX when the counter reaches 0.
- FIX (1 cycle): product = neg ? -acc : acc, in 2*WIDTH bits. The selected half is registered into result_o.
- DONE: resp_valid_o=1. result_o is held stable until resp_ready_i=1, then return to IDLE next cycle.
- Latency: accept to resp_valid_o is N+2 cycles (18 for 32/2). Throughput is one op per N+3 cycles minimum. No overlap of back-to-back requests.
- flush_i:
  - In any state, next state is IDLE, resp_valid_o=0 and any pending result is dropped.
  - flush_i has priority over accept and over resp_ready_i in the same cycle.
  - A flush in IDLE with req_valid_i=1 does not accept the request.
- rst_i mid-operation: immediate abort to reset values. No response is ever produced for the aborted request.
- resp_ready_i while resp_valid_o=0 is ignored.

Optional Feature:
MULT_PRODUCT_REUSE_EN
- With the macro defined:
  - The full 2*WIDTH product, op_A, op_B, signed_A and signed_B of the last completed op are stored, with a hit_valid flag.
  - A new request with identical operands and signedness (upper_i may differ) goes IDLE -> DONE. resp_valid_o asserts 1 cycle after accept, with the requested half.
  - hit_valid is cleared by rst_i and flush_i, and is set when FIX completes.
- Without the macro: no storage, and every request takes N+2 cycles.

Decomposition:
- Package multiplier_pkg_v7 holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - default WIDTH and RADIX_BITS constants;
  - the function clog2 used for the counter width.
- One natural sub-module, multiplier_pp_step_v7: combinational WIDTH x RADIX_BITS partial product plus accumulate-and-shift, instantiated once in CALC.

Test Plan:
- MUL signed/signed, A=7, B=0xFFFFFFFD, upper=0 -> result 0xFFFFFFEB, resp_valid_o exactly 18 cycles after accept.
- MULH with the same operands, upper=1 -> 0xFFFFFFFF. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. The same operands with upper=0 -> 0x00000001.
- MULH A=B=0x80000000 signed/signed -> 0x40000000. MULHSU A=0xFFFFFFFF (signed), B=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF.
- Backpressure: hold resp_ready_i=0 for 5 cycles -> result_o and resp_valid_o stable and req_ready_o=0 throughout. After the ready pulse, req_ready_o=1 one cycle later.
- Flush asserted at CALC cycle 4, and rst_i asserted at CALC cycle 8 of a second op -> no resp_valid_o for either; req_ready_o=1 next cycle. A following MUL 3*5 returns 0x0000000F.
- With MULT_PRODUCT_REUSE_EN: MULHU A=B=0xFFFFFFFF, then MUL with the same operands -> 0x00000001 with resp_valid_o 1 cycle after accept. A flush in between forces the full 18-cycle latency.

Source files
------------

// File: rtl/multiplier_param_v7_pkg.sv
// Shared state type, default sizes and counter-width helper for the iterative multiplier.
package multiplier_pkg_v7;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_RADIX_BITS = 2;

    // Ceiling log2, for sizing the iteration counter at elaboration time.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/multiplier_param_v7_pp_step.sv
// One radix step: WIDTH x RADIX_BITS partial product added into the upper half, then shift right.
module multiplier_pp_step_v7
    import multiplier_pkg_v7::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RADIX_BITS = DEF_RADIX_BITS
) (
    input  logic [2*WIDTH-RADIX_BITS-1:0] acc_keep,
    input  logic [WIDTH-1:0]              a_mag,
    input  logic [RADIX_BITS-1:0]         b_digit,
    output logic [2*WIDTH-1:0]            acc_next
);

    logic [WIDTH+RADIX_BITS-1:0] pp;
    logic [WIDTH+RADIX_BITS-1:0] sum;

    // acc_keep is the accumulator without the RADIX_BITS that this step shifts out.
    assign pp       = {{RADIX_BITS{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_digit};
    assign sum      = {{RADIX_BITS{1'b0}}, acc_keep[2*WIDTH-RADIX_BITS-1:WIDTH-RADIX_BITS]} + pp;
    assign acc_next = {sum, acc_keep[WIDTH-RADIX_BITS-1:0]};

endmodule

// File: rtl/multiplier_param_v7.sv
// Iterative sign-magnitude multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready and flush.
// Define MULT_PRODUCT_REUSE_EN to reuse the last full product for a repeated operand pair.
module multiplier_param_v7
    import multiplier_pkg_v7::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RADIX_BITS = DEF_RADIX_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] op_A_i,
    input  logic [WIDTH-1:0] op_B_i,
    input  logic             signed_A_i,
    input  logic             signed_B_i,
    input  logic             upper_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? clog2(N) : 1;

    if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
        $error("multiplier_param_v7: WIDTH must be a multiple of RADIX_BITS");
    end

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg, upper;
    logic [2*WIDTH-1:0] acc, acc_step, product;
    logic [CNT_W-1:0]   cnt;
    logic               accept, hit, a_neg, b_neg;
    logic [WIDTH-1:0]   hit_result;

    assign a_neg        = signed_A_i & op_A_i[WIDTH-1];
    assign b_neg        = signed_B_i & op_B_i[WIDTH-1];
    assign accept       = req_valid_i && (state == IDLE) && !flush_i;
    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == DONE) && !flush_i;
    assign product      = neg ? -acc : acc;

    multiplier_pp_step_v7 #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_pp_step (
        .acc_keep (acc[2*WIDTH-1:RADIX_BITS]),
        .a_mag    (a_mag),
        .b_digit  (b_mag[RADIX_BITS-1:0]),
        .acc_next (acc_step)
    );

`ifdef MULT_PRODUCT_REUSE_EN
    logic [2*WIDTH-1:0] last_product;
    logic [WIDTH-1:0]   last_a, last_b, req_a, req_b;
    logic               last_sa, last_sb, req_sa, req_sb, hit_valid;

    // upper_i is deliberately excluded: both halves come from the stored full product.
    assign hit = hit_valid && (op_A_i == last_a) && (op_B_i == last_b)
                 && (signed_A_i == last_sa) && (signed_B_i == last_sb);
    assign hit_result = upper_i ? last_product[2*WIDTH-1:WIDTH] : last_product[WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_product <= '0;
            last_a       <= '0;
            last_b       <= '0;
            last_sa      <= 1'b0;
            last_sb      <= 1'b0;
            req_a        <= '0;
            req_b        <= '0;
            req_sa       <= 1'b0;
            req_sb       <= 1'b0;
            hit_valid    <= 1'b0;
        end else if (flush_i) begin
            hit_valid <= 1'b0;
        end else begin
            if (accept) begin
                req_a  <= op_A_i;
                req_b  <= op_B_i;
                req_sa <= signed_A_i;
                req_sb <= signed_B_i;
            end
            if (state == FIX) begin
                hit_valid    <= 1'b1;
                last_product <= product;
                last_a       <= req_a;
                last_b       <= req_b;
                last_sa      <= req_sa;
                last_sb      <= req_sb;
            end
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = hit ? DONE : CALC;
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (resp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_mag    <= '0;
            b_mag    <= '0;
            neg      <= 1'b0;
            upper    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            a_mag <= a_neg ? -op_A_i : op_A_i;
            b_mag <= b_neg ? -op_B_i : op_B_i;
            neg   <= a_neg ^ b_neg;
            upper <= upper_i;
            acc   <= '0;
            cnt   <= CNT_W'(N - 1);
            if (hit) result_o <= hit_result;
        end else if (state == CALC && !flush_i) begin
            acc   <= acc_step;
            b_mag <= b_mag >> RADIX_BITS;
            cnt   <= cnt - CNT_W'(1);
        end else if (state == FIX && !flush_i) begin
            result_o <= upper ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_multiplier_param_v7.sv
// Directed bench for multiplier_param_v7 with a cycle-level reference model checked every cycle.
module tb_multiplier_param_v7;

    localparam int LAT = 18;
`ifdef MULT_PRODUCT_REUSE_EN
    localparam bit REUSE   = 1'b1;
    localparam int HIT_LAT = 1;
`else
    localparam bit REUSE   = 1'b0;
    localparam int HIT_LAT = LAT;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] op_A_i = '0;
    logic [31:0] op_B_i = '0;
    logic        signed_A_i = 1'b0;
    logic        signed_B_i = 1'b0;
    logic        upper_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    multiplier_param_v7 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_A_i       (op_A_i),
        .op_B_i       (op_B_i),
        .signed_A_i   (signed_A_i),
        .signed_B_i   (signed_B_i),
        .upper_i      (upper_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic up);
        logic signed [64:0]  xa, xb;
        logic signed [129:0] p;
        xa = sa ? {{33{a[31]}}, a} : {33'b0, a};
        xb = sb ? {{33{b[31]}}, b} : {33'b0, b};
        p  = xa * xb;
        return up ? p[63:32] : p[31:0];
    endfunction

    // Reference model: an op is in flight for LAT-1 cycles after accept, then held until taken.
    bit          m_busy = 0, m_valid = 0, m_hv = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_la = '0, m_lb = '0, p_a = '0, p_b = '0;
    logic        m_lsa = 0, m_lsb = 0, p_sa = 0, p_sb = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            check("reset req_ready", 64'(req_ready_o), 64'd1);
            check("reset resp_valid", 64'(resp_valid_o), 64'd0);
            check("reset result", 64'(result_o), 64'd0);
            m_busy  = 0;
            m_valid = 0;
            m_hv    = 0;
        end else begin
            check("req_ready", 64'(req_ready_o), 64'(!m_busy && !m_valid));
            check("resp_valid", 64'(resp_valid_o), 64'(m_valid && !flush_i));
            if (m_valid) check("result", 64'(result_o), 64'(m_res));
            if (flush_i) begin
                m_busy  = 0;
                m_valid = 0;
                m_hv    = 0;
            end else if (m_valid) begin
                if (resp_ready_i) m_valid = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 0;
                    m_valid = 1;
                    m_hv    = 1;
                    m_la = p_a; m_lb = p_b; m_lsa = p_sa; m_lsb = p_sb;
                end
            end else if (req_valid_i) begin
                m_res = ref_mul(op_A_i, op_B_i, signed_A_i, signed_B_i, upper_i);
                p_a = op_A_i; p_b = op_B_i; p_sa = signed_A_i; p_sb = signed_B_i;
                if (REUSE && m_hv && op_A_i == m_la && op_B_i == m_lb
                    && signed_A_i == m_lsa && signed_B_i == m_lsb) begin
                    m_valid = 1;
                end else begin
                    m_busy = 1;
                    m_left = LAT - 1;
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input logic up,
                         input bit chk_lit, input logic [31:0] lit, input int exp_lat, input int hold);
        int lat;
        @(posedge clk_i); #1;
        op_A_i = a; op_B_i = b; signed_A_i = sa; signed_B_i = sb; upper_i = up;
        req_valid_i = 1'b1; resp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        op_A_i = ~a; op_B_i = ~b; signed_A_i = ~sa; signed_B_i = ~sb; upper_i = ~up;
        lat = 1;
        while (!resp_valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        if (chk_lit) check({name, " result"}, 64'(result_o), 64'(lit));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check({name, " held result"}, 64'(result_o), 64'(lit));
            check({name, " held valid"}, 64'(resp_valid_o), 64'd1);
            check({name, " held req_ready"}, 64'(req_ready_o), 64'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        check({name, " req_ready after take"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic watch_no_resp(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o) seen++;
        end
        check({name, " stray responses"}, 64'(seen), 64'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk_i); #1;
        op_A_i = a; op_B_i = b; signed_A_i = 1'b0; signed_B_i = 1'b0; upper_i = 1'b0;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        do_op("mul_s_s",   32'd7,        32'hFFFFFFFD, 1, 1, 0, 1, 32'hFFFFFFEB, LAT, 0);
        do_op("mulh_s_s",  32'd7,        32'hFFFFFFFD, 1, 1, 1, 1, 32'hFFFFFFFF, HIT_LAT, 0);
        do_op("mulhu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 1, 32'hFFFFFFFE, LAT, 0);
        do_op("mulu_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h00000001, HIT_LAT, 0);
        do_op("mulh_min",  32'h80000000, 32'h80000000, 1, 1, 1, 1, 32'h40000000, LAT, 0);
        do_op("mulhsu_bp", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 1, 32'hFFFFFFFF, LAT, 5);
        do_op("mulhsu_mix", 32'h12345678, 32'h9ABCDEF0, 1, 0, 1, 0, 32'h0, LAT, 0);
        do_op("mulh_mix",  32'h9ABCDEF0, 32'h12345678, 1, 1, 1, 0, 32'h0, LAT, 0);
        do_op("mul_zero",  32'h00000000, 32'h80000000, 1, 1, 0, 1, 32'h00000000, LAT, 0);

        // Flush in CALC cycle 4.
        start_op(32'd9, 32'd11);
        repeat (3) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush req_ready", 64'(req_ready_o), 64'd1);
        watch_no_resp("flush", 25);

        // Reset in CALC cycle 8.
        start_op(32'd13, 32'd17);
        repeat (7) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        #1;
        check("async reset req_ready", 64'(req_ready_o), 64'd1);
        check("async reset resp_valid", 64'(resp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("post reset req_ready", 64'(req_ready_o), 64'd1);
        watch_no_resp("reset", 25);

        do_op("mul_3x5", 32'd3, 32'd5, 0, 0, 0, 1, 32'h0000000F, LAT, 0);

        // Flush in IDLE with a request present must not accept it.
        @(posedge clk_i); #1;
        op_A_i = 32'd4; op_B_i = 32'd4; req_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; flush_i = 1'b0;
        check("idle flush req_ready", 64'(req_ready_o), 64'd1);
        watch_no_resp("idle flush", 22);

        // Product reuse, then a flush forcing the full latency.
        do_op("reuse_hi",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 1, 32'hFFFFFFFE, LAT, 0);
        do_op("reuse_lo",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h00000001, HIT_LAT, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        do_op("reuse_flushed", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h00000001, LAT, 0);

        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
